// File: rtl/execution_monitor.sv
// execution_monitor: run-control, halt/timeout detection and execution statistics beside the CPU.
// Define EXEC_MONITOR_TRACE_EN to build the memory-write trace FIFO and its host-side port.
module execution_monitor #(
  parameter int PC_WIDTH       = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int STATE_WIDTH    = 3,
  parameter int FETCH_STATE    = 0,
  parameter int HALT_CYCLES    = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_WIDTH      = 32
`ifdef EXEC_MONITOR_TRACE_EN
  ,
  parameter int TRACE_DEPTH    = 8
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   cpu_running,
  input  logic [STATE_WIDTH-1:0] cpu_state,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   mem_write,
  input  logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic [DATA_WIDTH-1:0]  mem_write_data,
  output logic                   busy,
  output logic                   done,
  output logic                   halted,
  output logic                   timed_out,
  output logic [PC_WIDTH-1:0]    halt_pc,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic [CNT_WIDTH-1:0]   instr_count,
  output logic [CNT_WIDTH-1:0]   write_count
`ifdef EXEC_MONITOR_TRACE_EN
  ,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [ADDR_WIDTH-1:0]  trace_addr,
  output logic [DATA_WIDTH-1:0]  trace_data,
  output logic                   trace_overflow
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  localparam int STALL_W = $clog2(HALT_CYCLES + 1);

  state_t               state_reg, state_next;
  logic [STALL_W-1:0]   stall_reg, stall_next;
  logic [PC_WIDTH-1:0]  prev_pc_reg, halt_pc_reg;
  logic [CNT_WIDTH-1:0] cycle_count_reg, instr_count_reg, write_count_reg;
  logic                 halted_reg, timed_out_reg;
  logic                 in_run, clear, fetch, stuck, new_instr, halt_hit, timeout_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign in_run     = (state_reg == RUN);
  assign clear      = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign fetch      = (cpu_state == STATE_WIDTH'(FETCH_STATE));
  assign stuck      = fetch && (pc == prev_pc_reg);
  assign new_instr  = fetch && (pc != prev_pc_reg);
  assign stall_next = stuck ? stall_reg + STALL_W'(1) : '0;
  // Halt fires in the cycle the stall count reaches its limit; timeout fires in the cycle
  // that starts with cycle_count already at the limit, so both line up when pc never moves.
  assign halt_hit    = in_run && stuck && (stall_next == STALL_W'(HALT_CYCLES));
  assign timeout_hit = in_run && (cycle_count_reg >= CNT_WIDTH'(TIMEOUT_CYCLES));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ARMED;
      ARMED:   if (cpu_running) state_next = RUN;
      RUN:     if (halt_hit || timeout_hit || !cpu_running) state_next = DONE;
      DONE:    if (start) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      stall_reg       <= '0;
      prev_pc_reg     <= '1;
      halt_pc_reg     <= '0;
      cycle_count_reg <= '0;
      instr_count_reg <= '0;
      write_count_reg <= '0;
      halted_reg      <= 1'b0;
      timed_out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (clear) begin
        stall_reg       <= '0;
        prev_pc_reg     <= '1;
        halt_pc_reg     <= '0;
        cycle_count_reg <= '0;
        instr_count_reg <= '0;
        write_count_reg <= '0;
        halted_reg      <= 1'b0;
        timed_out_reg   <= 1'b0;
      end else if (in_run) begin
        stall_reg   <= stall_next;
        prev_pc_reg <= pc;
        // cycle_count stops at the timeout limit rather than counting the exit cycle
        if (!timeout_hit) cycle_count_reg <= sat_inc(cycle_count_reg);
        if (new_instr)    instr_count_reg <= sat_inc(instr_count_reg);
        if (mem_write)    write_count_reg <= sat_inc(write_count_reg);
        if (state_next == DONE) begin
          halt_pc_reg   <= pc;
          halted_reg    <= halt_hit;
          timed_out_reg <= timeout_hit && !halt_hit;
        end
      end
    end
  end

  assign busy        = (state_reg == ARMED) || (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign halted      = halted_reg;
  assign timed_out   = timed_out_reg;
  assign halt_pc     = halt_pc_reg;
  assign cycle_count = cycle_count_reg;
  assign instr_count = instr_count_reg;
  assign write_count = write_count_reg;

`ifdef EXEC_MONITOR_TRACE_EN
  // Write-trace FIFO; TRACE_DEPTH must be a power of two >= 2 so pointers wrap naturally.
  localparam int PTR_W   = $clog2(TRACE_DEPTH);
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0] fifo_mem [TRACE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     fill_reg;
  logic [ENTRY_W-1:0] hold_reg, head;
  logic               overflow_reg, push, pop, full, empty, accept;

  assign empty  = (fill_reg == '0);
  assign full   = (fill_reg == (PTR_W + 1)'(TRACE_DEPTH));
  assign push   = in_run && mem_write;
  assign pop    = !empty && trace_ready;
  assign accept = push && (!full || pop);
  assign head   = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (accept) fifo_mem[wr_ptr_reg] <= {mem_address, mem_write_data};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      hold_reg     <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      hold_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        hold_reg   <= head;
      end
      if (accept && !pop) fill_reg <= fill_reg + (PTR_W + 1)'(1);
      else if (pop && !accept) fill_reg <= fill_reg - (PTR_W + 1)'(1);
      if (push && !accept) overflow_reg <= 1'b1;
    end
  end

  // Once empty, the port keeps presenting the last entry handed to the host.
  assign trace_valid               = !empty;
  assign {trace_addr, trace_data}  = empty ? hold_reg : head;
  assign trace_overflow            = overflow_reg;
`else
  logic unused_trace_bits;
  assign unused_trace_bits = ^{mem_address, mem_write_data};
`endif

endmodule

// File: tb/tb_execution_monitor.sv
// Self-checking bench for execution_monitor: table-driven runs with a scoreboard queue,
// plus hand sequences for reset, start handling and (when built in) the trace FIFO.
`timescale 1ns/1ps
module tb_execution_monitor;
  localparam int PCW = 16, AW = 16, DW = 16, SW = 3, CW = 32;

  logic           clock = 1'b0, reset = 1'b0, start = 1'b0, cpu_running = 1'b0, mem_write = 1'b0;
  logic [SW-1:0]  cpu_state = '0;
  logic [PCW-1:0] pc = '0;
  logic [AW-1:0]  mem_address = '0;
  logic [DW-1:0]  mem_write_data = '0;

  logic           busy, done, halted, timed_out;
  logic [PCW-1:0] halt_pc;
  logic [CW-1:0]  cycle_count, instr_count, write_count;
  logic           busy_b, done_b, halted_b, timed_out_b;
  logic [PCW-1:0] halt_pc_b;
  logic [CW-1:0]  cycle_count_b, instr_count_b, write_count_b;
`ifdef EXEC_MONITOR_TRACE_EN
  logic           trace_ready = 1'b0;
  logic           trace_valid, trace_overflow, trace_valid_b, trace_overflow_b;
  logic [AW-1:0]  trace_addr, trace_addr_b;
  logic [DW-1:0]  trace_data, trace_data_b;
`endif

  always #5 clock = ~clock;

  execution_monitor #(.HALT_CYCLES(5), .TIMEOUT_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .start(start), .cpu_running(cpu_running),
    .cpu_state(cpu_state), .pc(pc), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .busy(busy), .done(done), .halted(halted),
    .timed_out(timed_out), .halt_pc(halt_pc), .cycle_count(cycle_count),
    .instr_count(instr_count), .write_count(write_count)
`ifdef EXEC_MONITOR_TRACE_EN
    , .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_overflow(trace_overflow)
`endif
  );

  execution_monitor #(.HALT_CYCLES(5), .TIMEOUT_CYCLES(5)) dut_b (
    .clock(clock), .reset(reset), .start(start), .cpu_running(cpu_running),
    .cpu_state(cpu_state), .pc(pc), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .busy(busy_b), .done(done_b), .halted(halted_b),
    .timed_out(timed_out_b), .halt_pc(halt_pc_b), .cycle_count(cycle_count_b),
    .instr_count(instr_count_b), .write_count(write_count_b)
`ifdef EXEC_MONITOR_TRACE_EN
    , .trace_valid(trace_valid_b), .trace_ready(trace_ready), .trace_addr(trace_addr_b),
    .trace_data(trace_data_b), .trace_overflow(trace_overflow_b)
`endif
  );

  typedef struct {
    bit use_b;
    int base, change, fetch_odd, n_writes, drop_at, start_at;
    bit exp_halted, exp_timed_out;
    int exp_halt_pc, exp_cycles, exp_cycle_count, exp_instr, exp_writes;
  } vec_t;

  int          checks = 0, errors = 0;
  vec_t        vecs [7];
  vec_t        sb [$];
  logic [31:0] tq [$];
  bit          exp_ovf;
  logic [15:0] wdata_tab [16];

  bit             sel_b = 1'b0;
  logic           s_done, s_halted, s_timed_out;
  logic [PCW-1:0] s_halt_pc;
  logic [CW-1:0]  s_cc, s_ic, s_wc;
  always_comb begin
    s_done = sel_b ? done_b : done;
    s_halted = sel_b ? halted_b : halted;
    s_timed_out = sel_b ? timed_out_b : timed_out;
    s_halt_pc = sel_b ? halt_pc_b : halt_pc;
    s_cc = sel_b ? cycle_count_b : cycle_count;
    s_ic = sel_b ? instr_count_b : instr_count;
    s_wc = sel_b ? write_count_b : write_count;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arm, enter RUN, then drive RUN cycle k=1.. until done; expected record rides the scoreboard.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t  e;
    int    done_k;
    string tag;
    done_k = -1;
    tag = $sformatf("v%0d", idx);
    sb.push_back(v);
    tq.delete();
    exp_ovf = 1'b0;
    sel_b = v.use_b;
    mem_write = 1'b0; cpu_running = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; cpu_running = 1'b1;
    tick();
    for (int k = 1; k <= 60; k++) begin
      pc = PCW'(v.base + (((k - 1) < v.change) ? (k - 1) : v.change));
      cpu_state = (v.fetch_odd != 0 && (k % 2) == 0) ? 3'd3 : 3'd0;
      cpu_running = (v.drop_at != k);
      start = (v.start_at == k);
      mem_write = (k <= v.n_writes);
      mem_address = AW'(16 + k - 1);
      mem_write_data = wdata_tab[(k - 1) % 16];
      if (mem_write) begin
        if (tq.size() < 8) tq.push_back({mem_address, mem_write_data});
        else exp_ovf = 1'b1;
      end
      tick();
      if (s_done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0; mem_write = 1'b0;
    e = sb.pop_front();
    check({tag, ".done_cycle"}, done_k, e.exp_cycles);
    check({tag, ".halted"}, s_halted, e.exp_halted);
    check({tag, ".timed_out"}, s_timed_out, e.exp_timed_out);
    check({tag, ".halt_pc"}, s_halt_pc, e.exp_halt_pc);
    check({tag, ".cycle_count"}, s_cc, e.exp_cycle_count);
    check({tag, ".instr_count"}, s_ic, e.exp_instr);
    check({tag, ".write_count"}, s_wc, e.exp_writes);
    $display("%s: done after %0d run cycles halted=%0b timed_out=%0b halt_pc=%0h cycles=%0d instr=%0d writes=%0d",
             tag, done_k, s_halted, s_timed_out, s_halt_pc, s_cc, s_ic, s_wc);
    cpu_running = 1'b0;
    tick();
  endtask

`ifdef EXEC_MONITOR_TRACE_EN
  task automatic drain(input string tag);
    logic [31:0] exp_e, last;
    last = '0;
    check({tag, ".overflow"}, trace_overflow, exp_ovf);
    trace_ready = 1'b1;
    while (tq.size() > 0) begin
      exp_e = tq.pop_front();
      check({tag, ".valid"}, trace_valid, 1'b1);
      check({tag, ".entry"}, {trace_addr, trace_data}, exp_e);
      $display("%s: popped addr=%04h data=%04h", tag, trace_addr, trace_data);
      last = exp_e;
      tick();
    end
    check({tag, ".valid_after"}, trace_valid, 1'b0);
    check({tag, ".hold"}, {trace_addr, trace_data}, last);
    trace_ready = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got unfinished run, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) wdata_tab[i] = 16'hA000 + 16'(i);
    wdata_tab[0] = 16'hBEEF; wdata_tab[1] = 16'h1234; wdata_tab[2] = 16'h0000;
    //           use_b base    chg fodd wr drop st | halt to  hpc    cyc cc  ic  wc
    vecs[0] = '{1'b0, 0,      10,   0, 2, 0,  0, 1'b1, 1'b0, 10,     16, 16, 11, 2};
    vecs[1] = '{1'b0, 'h200, 1000,  0, 2, 4,  2, 1'b0, 1'b0, 'h203,  4,  4,  4,  2};
    vecs[2] = '{1'b0, 0,     1000,  1, 0, 8,  0, 1'b0, 1'b0, 7,      8,  8,  4,  0};
    vecs[3] = '{1'b1, 'h50,   0,    0, 0, 0,  0, 1'b1, 1'b0, 'h50,   6,  5,  1,  0};
    vecs[4] = '{1'b0, 'h100, 1000,  0, 3, 0,  0, 1'b0, 1'b1, 'h114,  21, 20, 21, 3};
    vecs[5] = '{1'b0, 0,     1000,  0, 3, 4,  0, 1'b0, 1'b0, 3,      4,  4,  4,  3};
    vecs[6] = '{1'b0, 0,     1000,  0, 10, 11, 0, 1'b0, 1'b0, 10,    11, 11, 11, 10};

    // reset held for two cycles
    tick(); tick();
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.halted", halted, 1'b0);
    check("reset.timed_out", timed_out, 1'b0);
    check("reset.halt_pc", halt_pc, 0);
    check("reset.cycle_count", cycle_count, 0);
    check("reset.instr_count", instr_count, 0);
    check("reset.write_count", write_count, 0);
`ifdef EXEC_MONITOR_TRACE_EN
    check("reset.trace_valid", trace_valid, 1'b0);
    check("reset.trace_word", {trace_addr, trace_data}, 0);
    check("reset.trace_overflow", trace_overflow, 1'b0);
`endif
    reset = 1'b1;
    tick();

    // armed without the CPU running: waits indefinitely
    start = 1'b1; cpu_running = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("armed%0d.busy", i), busy, 1'b1);
      check($sformatf("armed%0d.done", i), done, 1'b0);
    end
    $display("armed: busy held for 20 cycles with cpu_running low");

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // start in DONE clears everything and re-arms
    sel_b = 1'b0;
    start = 1'b1; cpu_running = 1'b0;
    tick();
    start = 1'b0;
    check("restart.busy", busy, 1'b1);
    check("restart.done", done, 1'b0);
    check("restart.timed_out", timed_out, 1'b0);
    check("restart.halted", halted, 1'b0);
    check("restart.halt_pc", halt_pc, 0);
    check("restart.cycle_count", cycle_count, 0);
    check("restart.instr_count", instr_count, 0);
    check("restart.write_count", write_count, 0);
    $display("restart: busy=%0b cycle_count=%0d", busy, cycle_count);

    // asynchronous reset in the middle of a run
    cpu_running = 1'b1; cpu_state = 3'd0;
    tick();
    for (int i = 0; i < 3; i++) begin
      pc = PCW'(16'h300 + i);
      tick();
    end
    check("prereset.cycle_count", cycle_count, 3);
    #3 reset = 1'b0;
    #1;
    check("asyncreset.busy", busy, 1'b0);
    check("asyncreset.done", done, 1'b0);
    check("asyncreset.cycle_count", cycle_count, 0);
    check("asyncreset.instr_count", instr_count, 0);
    check("asyncreset.halt_pc", halt_pc, 0);
    $display("asyncreset: busy=%0b cycle_count=%0d", busy, cycle_count);
    #2 reset = 1'b1;
    cpu_running = 1'b0;
    tick();

`ifdef EXEC_MONITOR_TRACE_EN
    run_vec(5, vecs[5]);
    drain("trace3");
    run_vec(6, vecs[6]);
    drain("trace10");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("traceclr.overflow", trace_overflow, 1'b0);
    check("traceclr.valid", trace_valid, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
